bev_order_ctrl: RTL and testbench

BEV_ORDER_CTRL -- requirements
Module: bev_order_ctrl

---
 rtl/bev_order_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_bev_order_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bev_order_ctrl.sv
// Beverage order controller: collects order fields, reads one barrel record from DRAM,
// applies make/supply/check rules, writes back when needed and reports an error code.
module bev_order_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_action_valid,
    input  logic        type_valid,
    input  logic        size_valid,
    input  logic        date_valid,
    input  logic        box_no_valid,
    input  logic        box_sup_valid,
    input  logic [71:0] D,
    output logic        dram_req,
    output logic        dram_we,
    output logic [7:0]  dram_addr,
    output logic [63:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [63:0] dram_rdata,
    output logic        out_valid,
    output logic [1:0]  err_msg,
    output logic        complete
);

    typedef enum logic [2:0] {IDLE = 3'd0, GET = 3'd1, RD = 3'd2, CALC = 3'd3, WR = 3'd4, OUT = 3'd5} state_t;

    localparam logic [1:0] ACT_MAKE   = 2'd0;
    localparam logic [1:0] ACT_SUPPLY = 2'd1;
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_EXP    = 2'd1;
    localparam logic [1:0] ERR_ING    = 2'd2;
    localparam logic [1:0] ERR_OF     = 2'd3;

    // Dates are {month[8:5], day[4:0]}; equal dates are still valid.
    function automatic logic is_expired(input logic [8:0] today, input logic [8:0] exp_date);
        return (today[8:5] > exp_date[8:5]) ||
               ((today[8:5] == exp_date[8:5]) && (today[4:0] > exp_date[4:0]));
    endfunction

    function automatic logic [63:0] pack_barrel(input logic [3:0][11:0] bal, input logic [8:0] exp_date);
        return {bal[0], bal[1], 4'd0, exp_date[8:5], bal[2], bal[3], 3'd0, exp_date[4:0]};
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        action_q, action_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        size_q, size_d;
    logic [8:0]        date_q, date_d;
    logic [2:0]        fld_q, fld_d;
    logic              rd_done_q, rd_done_d;
    logic [3:0][11:0]  sup_q, sup_d;
    logic [3:0][11:0]  bal_q, bal_d;
    logic [8:0]        exp_q, exp_d;
    logic [1:0]        err_q, err_d;
    logic              dram_req_q, dram_req_d, dram_we_q, dram_we_d;
    logic [7:0]        dram_addr_q, dram_addr_d;
    logic [63:0]       dram_wdata_q, dram_wdata_d;
    logic              out_valid_q, out_valid_d, complete_q, complete_d;
    logic [1:0]        err_msg_q, err_msg_d;

    logic              is_make_s, is_supply_s, ack_s;
    logic [11:0]       vol_s, quarter_s, half_s, three_q_s;
    logic [3:0][11:0]  need_s, make_bal_s, sup_bal_s, new_bal_s;
    logic [12:0]       sum_s;
    logic              expired_s, short_s, of_s, wr_need_s;
    logic [1:0]        calc_err_s;
    logic [8:0]        new_exp_s;
    logic              unused_bits_s;

    assign unused_bits_s = ^{D[71:12], dram_rdata[39:36], dram_rdata[7:5]};
    assign is_make_s     = (action_q == ACT_MAKE);
    assign is_supply_s   = (action_q == ACT_SUPPLY);
    // Only an ack answering our own live request counts; stray acks after reset are dropped.
    assign ack_s         = dram_ack & dram_req_q;

    // Recipe needs, balance updates and the resulting error code for the captured order.
    always_comb begin
        case (size_q)
            2'd0:    vol_s = 12'd960;
            2'd1:    vol_s = 12'd720;
            default: vol_s = 12'd480;
        endcase
        quarter_s = vol_s >> 2;
        half_s    = vol_s >> 1;
        three_q_s = vol_s - quarter_s;
        need_s    = '0;
        case (type_q)
            3'd0:    need_s[0] = vol_s;
            3'd1:    begin need_s[0] = three_q_s; need_s[2] = quarter_s; end
            3'd2:    begin need_s[0] = half_s;    need_s[2] = half_s;    end
            3'd3:    need_s[1] = vol_s;
            3'd4:    begin need_s[1] = half_s;    need_s[2] = half_s;    end
            3'd5:    need_s[3] = vol_s;
            3'd6:    begin need_s[0] = half_s;    need_s[3] = half_s;    end
            default: begin need_s[0] = half_s; need_s[2] = quarter_s; need_s[3] = quarter_s; end
        endcase
        expired_s  = is_expired(date_q, exp_q);
        short_s    = 1'b0;
        of_s       = 1'b0;
        make_bal_s = '0;
        sup_bal_s  = '0;
        sum_s      = 13'd0;
        for (int i = 0; i < 4; i++) begin
            short_s       = short_s | (need_s[i] > bal_q[i]);
            make_bal_s[i] = bal_q[i] - need_s[i];
            sum_s         = {1'b0, bal_q[i]} + {1'b0, sup_q[i]};
            of_s          = of_s | sum_s[12];
            sup_bal_s[i]  = sum_s[12] ? 12'hFFF : sum_s[11:0];
        end
        case (action_q)
            ACT_MAKE: begin
                calc_err_s = expired_s ? ERR_EXP : (short_s ? ERR_ING : ERR_NONE);
                wr_need_s  = !expired_s && !short_s;
                new_bal_s  = make_bal_s;
                new_exp_s  = exp_q;
            end
            ACT_SUPPLY: begin
                calc_err_s = of_s ? ERR_OF : ERR_NONE;
                wr_need_s  = 1'b1;
                new_bal_s  = sup_bal_s;
                new_exp_s  = date_q;
            end
            default: begin
                calc_err_s = expired_s ? ERR_EXP : ERR_NONE;
                wr_need_s  = 1'b0;
                new_bal_s  = bal_q;
                new_exp_s  = exp_q;
            end
        endcase
    end

    // Next-state, field capture and DRAM/result output decisions.
    always_comb begin
        state_d      = state_q;
        action_d     = action_q;
        type_d       = type_q;
        size_d       = size_q;
        date_d       = date_q;
        fld_d        = fld_q;
        rd_done_d    = rd_done_q;
        sup_d        = sup_q;
        bal_d        = bal_q;
        exp_d        = exp_q;
        err_d        = err_q;
        dram_req_d   = dram_req_q;
        dram_we_d    = dram_we_q;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        out_valid_d  = 1'b0;
        err_msg_d    = 2'd0;
        complete_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_action_valid) begin
                    action_d  = D[1:0];
                    fld_d     = 3'd0;
                    rd_done_d = 1'b0;
                    sup_d     = '0;
                    state_d   = GET;
                end else begin
                    state_d = IDLE;
                end
            end
            GET: begin
                // fld_q walks type/size/date/box for make, date/box otherwise.
                if (is_make_s && (fld_q == 3'd0) && type_valid) begin
                    type_d = D[2:0];
                    fld_d  = fld_q + 3'd1;
                end else if (is_make_s && (fld_q == 3'd1) && size_valid) begin
                    size_d = D[1:0];
                    fld_d  = fld_q + 3'd1;
                end else if (((is_make_s && (fld_q == 3'd2)) || (!is_make_s && (fld_q == 3'd0))) && date_valid) begin
                    date_d = D[8:0];
                    fld_d  = fld_q + 3'd1;
                end else if (((is_make_s && (fld_q == 3'd3)) || (!is_make_s && (fld_q == 3'd1))) && box_no_valid) begin
                    dram_addr_d  = D[7:0];
                    dram_req_d   = 1'b1;
                    dram_we_d    = 1'b0;
                    dram_wdata_d = 64'd0;
                    fld_d        = 3'd0;
                    state_d      = RD;
                end else begin
                    state_d = GET;
                end
            end
            RD: begin
                if (ack_s) begin
                    bal_d[0]   = dram_rdata[63:52];
                    bal_d[1]   = dram_rdata[51:40];
                    bal_d[2]   = dram_rdata[31:20];
                    bal_d[3]   = dram_rdata[19:8];
                    exp_d      = {dram_rdata[35:32], dram_rdata[4:0]};
                    rd_done_d  = 1'b1;
                    dram_req_d = 1'b0;
                end else begin
                    rd_done_d = rd_done_q;
                end
                if (is_supply_s && (fld_q < 3'd4) && box_sup_valid) begin
                    sup_d[fld_q[1:0]] = D[11:0];
                    fld_d             = fld_q + 3'd1;
                end else begin
                    fld_d = fld_q;
                end
                if (rd_done_d && (!is_supply_s || (fld_d == 3'd4))) begin
                    state_d = CALC;
                end else begin
                    state_d = RD;
                end
            end
            CALC: begin
                err_d = calc_err_s;
                if (wr_need_s) begin
                    dram_req_d   = 1'b1;
                    dram_we_d    = 1'b1;
                    dram_wdata_d = pack_barrel(new_bal_s, new_exp_s);
                    state_d      = WR;
                end else begin
                    out_valid_d = 1'b1;
                    err_msg_d   = calc_err_s;
                    complete_d  = (calc_err_s == ERR_NONE);
                    state_d     = OUT;
                end
            end
            WR: begin
                if (ack_s) begin
                    dram_req_d  = 1'b0;
                    dram_we_d   = 1'b0;
                    out_valid_d = 1'b1;
                    err_msg_d   = err_q;
                    complete_d  = (err_q == ERR_NONE);
                    state_d     = OUT;
                end else begin
                    state_d = WR;
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            action_q     <= 2'd0;
            type_q       <= 3'd0;
            size_q       <= 2'd0;
            date_q       <= 9'd0;
            fld_q        <= 3'd0;
            rd_done_q    <= 1'b0;
            sup_q        <= '0;
            bal_q        <= '0;
            exp_q        <= 9'd0;
            err_q        <= 2'd0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= 8'd0;
            dram_wdata_q <= 64'd0;
            out_valid_q  <= 1'b0;
            err_msg_q    <= 2'd0;
            complete_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            action_q     <= action_d;
            type_q       <= type_d;
            size_q       <= size_d;
            date_q       <= date_d;
            fld_q        <= fld_d;
            rd_done_q    <= rd_done_d;
            sup_q        <= sup_d;
            bal_q        <= bal_d;
            exp_q        <= exp_d;
            err_q        <= err_d;
            dram_req_q   <= dram_req_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            out_valid_q  <= out_valid_d;
            err_msg_q    <= err_msg_d;
            complete_q   <= complete_d;
        end
    end

    assign dram_req   = dram_req_q;
    assign dram_we    = dram_we_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;
    assign out_valid  = out_valid_q;
    assign err_msg    = err_msg_q;
    assign complete   = complete_q;

endmodule

// File: tb/tb_bev_order_ctrl.sv
// Randomized bench for bev_order_ctrl: a DRAM responder with programmable latency and a
// recipe-level reference model of the barrel store.
module tb_bev_order_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stb;               // 0 sel, 1 type, 2 size, 3 date, 4 box, 5 supply
    logic [71:0] D;
    logic        dram_req, dram_we, dram_ack, out_valid, complete;
    logic [7:0]  dram_addr;
    logic [63:0] dram_wdata, dram_rdata;
    logic [1:0]  err_msg;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_reads = 0, n_writes = 0;
    int rd_delay = 0, wr_delay = 0, wcnt = 0;
    int rd_ack_cyc = 0, wr_ack_cyc = 0, last_stb_cyc = 0;
    bit prev_req = 1'b0, stray_ack = 1'b0;
    logic [63:0] mem [0:255];
    logic [63:0] ref_mem [0:255];
    int qt [0:7][0:3] = '{'{4,0,0,0}, '{3,0,1,0}, '{2,0,2,0}, '{0,4,0,0},
                          '{0,2,2,0}, '{0,0,0,4}, '{2,0,0,2}, '{2,0,1,1}};

    bev_order_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .sel_action_valid(stb[0]), .type_valid(stb[1]), .size_valid(stb[2]),
        .date_valid(stb[3]), .box_no_valid(stb[4]), .box_sup_valid(stb[5]),
        .D(D), .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_ack(dram_ack), .dram_rdata(dram_rdata),
        .out_valid(out_valid), .err_msg(err_msg), .complete(complete)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] barrel(input int bt, gt, mk, pa, m, d);
        logic [11:0] b0, b1, b2, b3;
        logic [3:0]  mm;
        logic [4:0]  dd;
        b0 = 12'(bt); b1 = 12'(gt); b2 = 12'(mk); b3 = 12'(pa); mm = 4'(m); dd = 5'(d);
        return {b0, b1, 4'd0, mm, b2, b3, 3'd0, dd};
    endfunction

    function automatic logic [71:0] garbage();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    // DRAM model: answers each request after a programmable number of cycles.
    initial begin
        dram_ack = 1'b0; dram_rdata = 64'd0;
        forever begin
            @(negedge clk); #1;
            dram_ack = 1'b0; dram_rdata = 64'd0;
            if (stray_ack) begin
                dram_ack = 1'b1;
            end else if (dram_req) begin
                if (!prev_req) wcnt = dram_we ? wr_delay : rd_delay;
                if (wcnt == 0) begin
                    dram_ack = 1'b1;
                    if (dram_we) begin
                        mem[dram_addr] = dram_wdata; n_writes++; wr_ack_cyc = cyc;
                    end else begin
                        dram_rdata = mem[dram_addr]; n_reads++; rd_ack_cyc = cyc;
                    end
                end else begin
                    wcnt--;
                end
            end
            prev_req = dram_req;
        end
    end

    function automatic int pick_stray(input logic [1:0] act);
        int r;
        r = $urandom_range(0, 3);
        if (act == 2'd0) return (r < 2) ? 0 : 5;
        if (act == 2'd1) return (r == 3) ? 0 : r;
        return (r == 3) ? 5 : r;
    endfunction

    task automatic gap(input int n, input logic [1:0] act, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            stb = '0; D = garbage();
            if (stray && ($urandom_range(0, 1) == 0)) stb[pick_stray(act)] = 1'b1;
        end
    endtask

    task automatic pulse(input int idx, input logic [71:0] val);
        @(negedge clk);
        stb = '0; stb[idx] = 1'b1; D = val; last_stb_cyc = cyc;
    endtask

    task automatic drive_fields(input logic [1:0] act, input logic [2:0] typ, input logic [1:0] sz,
                                input logic [8:0] today, input logic [7:0] box,
                                input logic [3:0][11:0] sup, input int maxgap, input bit stray);
        pulse(0, 72'(act));
        if (act == 2'd0) begin
            gap($urandom_range(0, maxgap), act, stray); pulse(1, 72'(typ));
            gap($urandom_range(0, maxgap), act, stray); pulse(2, 72'(sz));
        end
        gap($urandom_range(0, maxgap), act, stray); pulse(3, 72'(today));
        gap($urandom_range(0, maxgap), act, stray); pulse(4, 72'(box));
        if (act == 2'd1) begin
            for (int i = 0; i < 4; i++) begin
                gap($urandom_range(0, maxgap), act, stray); pulse(5, 72'(sup[i]));
            end
        end
    endtask

    task automatic run_txn(input logic [1:0] act, input logic [2:0] typ, input logic [1:0] sz,
                           input int tm, input int td, input logic [7:0] box,
                           input logic [3:0][11:0] sup, input int rdd, input int wrd,
                           input int maxgap, input bit stray);
        logic [63:0] w, exp_w;
        int bal[4], nb[4], need[4], vol, em, ed, exp_err, r0, w0, exp_cyc, got_cyc;
        bit expired, short, of, wr, found;
        w = ref_mem[box];
        bal[0] = int'(w[63:52]); bal[1] = int'(w[51:40]);
        bal[2] = int'(w[31:20]); bal[3] = int'(w[19:8]);
        em = int'(w[35:32]); ed = int'(w[4:0]);
        expired = (tm * 32 + td) > (em * 32 + ed);
        vol = (sz == 2'd0) ? 960 : ((sz == 2'd1) ? 720 : 480);
        short = 1'b0; of = 1'b0;
        for (int i = 0; i < 4; i++) begin
            need[i] = vol * qt[typ][i] / 4;
            if (need[i] > bal[i]) short = 1'b1;
        end
        exp_w = w; wr = 1'b0;
        if (act == 2'd0) begin
            exp_err = expired ? 1 : (short ? 2 : 0);
            wr = (exp_err == 0);
            for (int i = 0; i < 4; i++) nb[i] = bal[i] - need[i];
            if (wr) exp_w = barrel(nb[0], nb[1], nb[2], nb[3], em, ed);
        end else if (act == 2'd1) begin
            for (int i = 0; i < 4; i++) begin
                nb[i] = bal[i] + int'(sup[i]);
                if (nb[i] > 4095) begin nb[i] = 4095; of = 1'b1; end
            end
            exp_err = of ? 3 : 0;
            wr = 1'b1;
            exp_w = barrel(nb[0], nb[1], nb[2], nb[3], tm, td);
        end else begin
            exp_err = expired ? 1 : 0;
        end
        rd_delay = rdd; wr_delay = wrd; r0 = n_reads; w0 = n_writes;
        drive_fields(act, typ, sz, {4'(tm), 5'(td)}, box, sup, maxgap, stray);
        found = 1'b0; got_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            stb = '0; D = garbage();
            if (out_valid) begin found = 1'b1; got_cyc = cyc; break; end
        end
        chk("out_valid_seen", 64'(found), 64'd1);
        exp_cyc = wr ? (wr_ack_cyc + 1) : (((last_stb_cyc > rd_ack_cyc) ? last_stb_cyc : rd_ack_cyc) + 2);
        chk("latency", 64'(got_cyc), 64'(exp_cyc));
        chk("err_msg", 64'(err_msg), 64'(exp_err));
        chk("complete", 64'(complete), 64'(exp_err == 0));
        @(negedge clk);
        chk("out_valid_one_cycle", 64'(out_valid), 64'd0);
        chk("dram_reads", 64'(n_reads - r0), 64'd1);
        chk("dram_writes", 64'(n_writes - w0), 64'(wr));
        chk("barrel_word", mem[box], exp_w);
        ref_mem[box] = exp_w;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"}, 64'(dram_req), 64'd0);
        chk({tag, "_we"}, 64'(dram_we), 64'd0);
        chk({tag, "_addr"}, 64'(dram_addr), 64'd0);
        chk({tag, "_wdata"}, dram_wdata, 64'd0);
        chk({tag, "_out"}, 64'({out_valid, err_msg, complete}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0][11:0] s;
        bit found;
        int w0;
        stb = '0; D = 72'd0; rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = barrel($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                            $urandom_range(0, 4095), $urandom_range(1, 12), $urandom_range(1, 31));
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        s = '0;

        mem[5] = barrel(1000, 0, 0, 0, 3, 10); ref_mem[5] = mem[5];
        run_txn(2'd0, 3'd0, 2'd0, 3, 10, 8'd5, s, 3, 2, 2, 1'b0);
        chk("black_tea_bt", 64'(mem[5][63:52]), 64'd40);

        mem[6] = barrel(360, 500, 119, 0, 12, 31); ref_mem[6] = mem[6];
        run_txn(2'd0, 3'd1, 2'd3, 1, 1, 8'd6, s, 1, 1, 1, 1'b0);

        mem[7] = barrel(10, 10, 10, 10, 3, 31); ref_mem[7] = mem[7];
        run_txn(2'd2, 3'd0, 2'd0, 4, 1, 8'd7, s, 4, 0, 2, 1'b1);

        mem[8] = barrel(4000, 0, 0, 0, 1, 1); ref_mem[8] = mem[8];
        s[0] = 12'd100;
        run_txn(2'd1, 3'd0, 2'd0, 6, 15, 8'd8, s, 2, 3, 1, 1'b0);
        chk("supply_sat_bt", 64'(mem[8][63:52]), 64'd4095);

        s[0] = 12'd5; s[1] = 12'd6; s[2] = 12'd7; s[3] = 12'd8;
        run_txn(2'd1, 3'd0, 2'd0, 7, 4, 8'd8, s, 40, 2, 0, 1'b1);

        // Reset while the write request is pending.
        mem[9] = barrel(100, 100, 100, 100, 5, 5); ref_mem[9] = mem[9];
        rd_delay = 1; wr_delay = 60; w0 = n_writes;
        drive_fields(2'd1, 3'd0, 2'd0, {4'd5, 5'd6}, 8'd9, s, 1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            stb = '0;
            if (dram_req && dram_we) begin found = 1'b1; break; end
        end
        chk("wr_req_seen", 64'(found), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_quiet("midreset");
        rst_n = 1'b1; stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("after_stray_ack");
        chk("midreset_writes", 64'(n_writes - w0), 64'd0);
        chk("midreset_mem", mem[9], ref_mem[9]);
        run_txn(2'd1, 3'd0, 2'd0, 5, 6, 8'd9, s, 2, 2, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) s[i] = 12'($urandom_range(0, 4095) >> $urandom_range(0, 4));
            run_txn(2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom_range(1, 12), $urandom_range(1, 31), 8'($urandom_range(0, 7)), s,
                    $urandom_range(0, 30), $urandom_range(0, 10), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
